// File: rtl/poly_reduce_ctrl.sv
// poly_reduce_ctrl: in-place Barrett reduction of an N-coefficient polynomial; define POLY_REDUCE_CANON_EN for canonical [0,q-1] output (LAT 3)
module barret_reduce_pipe #(
  parameter int KYBER_Q = 3329
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data
);
  localparam int V = ((1 << 26) + KYBER_Q / 2) / KYBER_Q;
  logic signed [31:0] w_t;
  logic signed [31:0] w_r;
  always_comb begin
    w_t = (32'(i_data) * 32'(V) + 32'sd33554432) >>> 26;
    w_r = 32'(i_data) - w_t * 32'(KYBER_Q);
  end
  always_ff @(posedge clk) o_data <= rst ? '0 : w_r[15:0];
endmodule

module poly_reduce_ctrl #(
  parameter int KYBER_Q = 3329,
  parameter int N = 256,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_cnt, r_a1, r_a2, w_wa;
  logic r_v1, r_v2, w_wv;
  logic signed [15:0] w_red;
  logic [15:0] w_wd;
  barret_reduce_pipe #(.KYBER_Q(KYBER_Q)) u_red (
    .clk    (clk),
    .rst    (rst),
    .i_data (rd_data),
    .o_data (w_red)
  );
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE && start)) r_cnt <= '0;
    else if (r_state == RUN) r_cnt <= r_cnt + AW'(1);
  end
  always_ff @(posedge clk) begin
    r_v1 <= !rst && r_state == RUN;
    r_a1 <= rst ? '0 : r_cnt;
    r_v2 <= !rst && r_v1;
    r_a2 <= rst ? '0 : r_a1;
  end
`ifdef POLY_REDUCE_CANON_EN
  logic r_v3;
  logic [AW-1:0] r_a3;
  logic [15:0] r_d3;
  always_ff @(posedge clk) begin
    r_v3 <= !rst && r_v2;
    r_a3 <= rst ? '0 : r_a2;
    r_d3 <= rst ? '0 : (w_red[15] ? w_red + 16'(KYBER_Q) : w_red);
  end
  assign w_wv = r_v3;
  assign w_wa = r_a3;
  assign w_wd = r_d3;
`else
  assign w_wv = r_v2;
  assign w_wa = r_a2;
  assign w_wd = w_red;
`endif
  always_comb begin
    w_next = r_state == IDLE  ? (start ? RUN : IDLE) :
             r_state == RUN   ? (r_cnt == AW'(N - 1) ? DRAIN : RUN) :
             r_state == DRAIN ? ((w_wv && w_wa == AW'(N - 1)) ? DONE : DRAIN) : IDLE;
    busy    = !rst && (r_state == RUN || r_state == DRAIN);
    done    = !rst && r_state == DONE;
    rd_en   = !rst && r_state == RUN;
    rd_addr = rd_en ? r_cnt : '0;
    wr_en   = !rst && w_wv;
    wr_addr = wr_en ? w_wa : '0;
    wr_data = wr_en ? w_wd : '0;
  end
endmodule

// File: tb/tb_poly_reduce_ctrl.sv
// tb_poly_reduce_ctrl: randomized self-checking bench against a modular-arithmetic RAM model
module tb_poly_reduce_ctrl;
  localparam int Q = 3329;
  localparam int N = 256;
`ifdef POLY_REDUCE_CANON_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int D = N + LAT + 1;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic busy, done, rd_en, wr_en;
  logic [7:0] rd_addr, wr_addr;
  logic [15:0] rd_data, wr_data;
  logic [15:0] ram [N];
  logic [15:0] orig [N];
  logic [15:0] rd_q = '0;
  int n_done, n_rd, n_wr;
  int checks = 0;
  int errs = 0;
  poly_reduce_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );
  always #5 clk = ~clk;
  assign rd_data = rd_q;
  always @(posedge clk) begin
    if (rd_en) rd_q <= ram[rd_addr];
    if (wr_en) ram[wr_addr] <= wr_data;
    if (done) n_done++;
    if (rd_en) n_rd++;
    if (wr_en) n_wr++;
  end
  function automatic logic [15:0] model(input logic [15:0] x);
    int v, r;
    v = int'($signed(x));
    r = ((v % Q) + Q) % Q;
`ifndef POLY_REDUCE_CANON_EN
    if (r > (Q - 1) / 2) r = r - Q;
`endif
    return r[15:0];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill_random;
    for (int i = 0; i < N; i++) begin
      ram[i] = 16'($urandom);
      orig[i] = ram[i];
    end
  endtask
  task automatic check_ram(input string nm, input int thr);
    logic [15:0] e;
    for (int i = 0; i < N; i++) begin
      e = i < thr ? model(orig[i]) : orig[i];
      checks++;
      if (ram[i] !== e) begin
        errs++;
        $display("FAIL %s ram[%0d] got %h expected %h (input %h)", nm, i, ram[i], e, orig[i]);
      end
    end
  endtask
  task automatic pulse_start;
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 1000) begin
      tick;
      t++;
    end
    checks++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL %s done timeout got %b expected 1", nm, done);
    end
    tick;
  endtask
  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data} !== 36'd0) begin
      errs++;
      $display("FAIL %s outputs got busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%h wr_addr=%h wr_data=%h expected all 0",
               nm, busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    start = 1;
    #1;
    check_idle_outputs("reset_during");
    for (int i = 0; i < 3; i++) begin
      tick;
      check_idle_outputs("reset_held");
    end
    rst = 0;
    start = 0;
    tick;
    check_idle_outputs("reset_after");
  endtask
  task automatic test_timing;
    logic [19:0] got, exp;
    int k;
    fill_random;
    n_done = 0;
    pulse_start;
    for (k = 1; k <= N + LAT + 6; k++) begin
      exp[19] = k <= N + LAT;
      exp[18] = k == D;
      exp[17] = k <= N;
      exp[16:9] = k <= N ? 8'(k - 1) : 8'd0;
      exp[8] = k >= 1 + LAT && k <= N + LAT;
      exp[7:0] = exp[8] ? 8'(k - 1 - LAT) : 8'd0;
      got = {busy, done, rd_en, rd_addr, wr_en, wr_addr};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL timing cycle %0d {busy,done,rd_en,rd_addr,wr_en,wr_addr} got %h expected %h", k, got, exp);
      end
      tick;
    end
    checks++;
    if (n_done !== 1) begin
      errs++;
      $display("FAIL timing done_count got %0d expected 1", n_done);
    end
    check_ram("timing", N);
  endtask
  task automatic test_values;
    logic [15:0] vin [5];
    logic [15:0] vexp [5];
    vin = '{16'd3329, 16'd6658, 16'd3328, 16'hFFFF, 16'd32767};
`ifdef POLY_REDUCE_CANON_EN
    vexp = '{16'd0, 16'd0, 16'd3328, 16'd3328, 16'd2806};
`else
    vexp = '{16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFDF5};
`endif
    fill_random;
    for (int i = 0; i < 5; i++) begin
      ram[i] = vin[i];
      orig[i] = vin[i];
    end
    pulse_start;
    wait_done("values");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ram[i] !== vexp[i]) begin
        errs++;
        $display("FAIL values ram[%0d] got %h expected %h", i, ram[i], vexp[i]);
      end
    end
    check_ram("values", N);
  endtask
  task automatic test_start_held;
    logic e;
    fill_random;
    n_done = 0;
    n_rd = 0;
    start = 1;
    for (int k = 1; k <= 300; k++) begin
      tick;
      e = k <= N || (k >= D + 2 && k <= D + 1 + N);
      checks++;
      if ({rd_en, done} !== {e, 1'(k == D)}) begin
        errs++;
        $display("FAIL start_held cycle %0d {rd_en,done} got %b%b expected %b%b", k, rd_en, done, e, k == D);
      end
    end
    start = 0;
    wait_done("start_held");
    checks++;
    if (n_done !== 2 || n_rd !== 2 * N) begin
      errs++;
      $display("FAIL start_held passes got done=%0d reads=%0d expected done=2 reads=%0d", n_done, n_rd, 2 * N);
    end
    check_ram("start_held", N);
  endtask
  task automatic test_drain_start;
    fill_random;
    n_done = 0;
    n_rd = 0;
    pulse_start;
    for (int i = 0; i < N; i++) tick;
    checks++;
    if ({busy, rd_en} !== 2'b10) begin
      errs++;
      $display("FAIL drain_state {busy,rd_en} got %b%b expected 10", busy, rd_en);
    end
    pulse_start;
    for (int i = 0; i < 300; i++) tick;
    checks++;
    if (n_done !== 1 || n_rd !== N || busy !== 1'b0) begin
      errs++;
      $display("FAIL drain_start got done=%0d reads=%0d busy=%b expected done=1 reads=%0d busy=0", n_done, n_rd, busy, N);
    end
    check_ram("drain_start", N);
  endtask
  task automatic test_reset_mid;
    fill_random;
    pulse_start;
    for (int i = 1; i < 100; i++) tick;
    rst = 1;
    #1;
    checks++;
    if ({wr_en, rd_en, done} !== 3'b000) begin
      errs++;
      $display("FAIL reset_mid_now {wr_en,rd_en,done} got %b%b%b expected 000", wr_en, rd_en, done);
    end
    tick;
    check_idle_outputs("reset_mid_next");
    rst = 0;
    n_done = 0;
    n_wr = 0;
    for (int i = 0; i < 300; i++) tick;
    checks++;
    if (n_done !== 0 || n_wr !== 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_after got done=%0d writes=%0d busy=%b expected 0 0 0", n_done, n_wr, busy);
    end
    check_ram("reset_mid", 99 - LAT);
  endtask
  task automatic test_back_to_back;
    fill_random;
    pulse_start;
    wait_done("b2b_first");
    pulse_start;
    wait_done("b2b_second");
    check_ram("b2b", N);
  endtask
  initial begin
    test_reset;
    test_timing;
    test_values;
    test_start_held;
    test_drain_start;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/poly_reduce_ctrl.md
POLY_REDUCE_CTRL -- requirements
Module: poly_reduce_ctrl

Interface
REQ-001 SHALL have parameter KYBER_Q, default 3329, the modulus passed to the internal Barrett reducer.
REQ-002 SHALL have parameter N, default 256, the coefficients per polynomial; the address width is $clog2(N).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to reduce the whole polynomial.
REQ-006 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-007 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-008 SHALL have port rd_en, output, 1, the read strobe to the coefficient RAM.
REQ-009 SHALL have port rd_addr, output, 8, the read address.
REQ-010 SHALL have port rd_data, input, 16, the signed coefficient, valid the cycle after rd_en.
REQ-011 SHALL have port wr_en, output, 1, the write strobe.
REQ-012 SHALL have port wr_addr, output, 8, the write-back address.
REQ-013 SHALL have port wr_data, output, 16, the reduced coefficient.

Function
REQ-014 SHALL instantiate one barret_reduce_pipe (1 register stage) fed by rd_data and shall reduce coefficients in place.
REQ-015 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE; after reset the state is IDLE.
REQ-016 SHALL, in IDLE, accept start, clear the address counter and go to RUN; start in any other state is ignored.
REQ-017 SHALL, in RUN, assert rd_en with rd_addr = 0,1,...,N-1 on consecutive cycles with no gaps, and go to DRAIN after address N-1.
REQ-018 SHALL pipe a valid bit and address alongside the data; wr_en/wr_addr shall equal rd_en/rd_addr delayed by LAT cycles (LAT=2, or 3 per REQ-027).
REQ-019 SHALL, in DRAIN, wait until the last write (address N-1) has issued, then go to DONE.
REQ-020 SHALL, in DONE, pulse done for exactly one cycle and return to IDLE; busy is high in RUN and DRAIN.
REQ-021 SHALL give the timing for start sampled at cycle 0: reads at cycles 1..N, writes at cycles 1+LAT..N+LAT, done at cycle N+LAT+1.
REQ-022 SHALL produce wr_data as the 16-bit two's-complement Barrett result, the centred representative in [-(q-1)/2, (q-1)/2]; no saturation.
REQ-023 SHALL never issue a read and a write to the same address in the same cycle; the RAM is assumed to have separate ports.

Reset
REQ-024 SHALL, when rst is high at a clock edge, force state IDLE, counter 0, and pipeline valid bits 0.
REQ-025 SHALL hold busy, done, rd_en, wr_en, rd_addr, wr_addr and wr_data at 0 during and immediately after reset.
REQ-026 SHALL, on reset mid-operation, issue no further writes; in-flight coefficients are discarded and the RAM is partially updated.

Configuration
REQ-027 SHALL use macro POLY_REDUCE_CANON_EN; when defined, an extra register stage adds KYBER_Q to negative Barrett results, making wr_data canonical in [0, q-1] and LAT = 3.
REQ-028 SHALL, without POLY_REDUCE_CANON_EN, output the centred representative with LAT = 2.

Verification
REQ-029 SHALL cover: reset, then start at cycle 0 -> rd_en at cycles 1..256, wr_en at cycles 3..258, done exactly at cycle 259 (260/4..259 with the macro).
REQ-030 SHALL cover: RAM preloaded with 3329, 6658, 3328, 0xFFFF, 32767 -> written values 0, 0, 0xFFFF, 0xFFFF, 0xFDF5; with the macro 0, 0, 3328, 3328, 2806.
REQ-031 SHALL cover: start held high for 300 cycles -> exactly one pass per IDLE entry, and a second pass begins only after done.
REQ-032 SHALL cover: rst asserted at cycle 100 of RUN -> wr_en is 0 from the next cycle, done is never pulsed, and addresses at or above 97 (LAT=2) are unmodified.
REQ-033 SHALL cover: start pulse during DRAIN -> ignored, with no extra reads and a single done.
